maze_mem_arbiter: RTL and testbench
===================================

# maze_mem_arbiter

Shares the single 16x16, 1-bit maze memory between the rat engine (path search, visit marking) and the host map loader. Fair round-robin arbitration when both sides access the memory in the same cycle. Sequences the map-restore handshake: a rat `rst_map` request locks the rat out, asks the host to reload the maze, and releases the rat on completion or watchdog timeout. Sits between the intelligent-rat top and the maze RAM.

## Interface
- `ADDR_W`, 4: coordinate width per axis; the memory has 2^ADDR_W x 2^ADDR_W cells.
- `TIMEOUT`, 512: reload watchdog limit, in cycles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rat_rd`, `rat_wr` in 1: rat access request; level, held until granted; never both high.
- `rat_x`, `rat_y` in ADDR_W: rat cell coordinates.
- `rat_din` in 1: rat write data.
- `rat_rst_map` in 1: one-cycle pulse requesting a map restore.
- `rat_gnt` out 1: rat access performed this cycle.
- `rat_dout` out 1: rat read data.
- `rat_rvalid` out 1: rat read data valid.
- `rat_busy` out 1: reload in progress; rat requests are not granted.
- `host_rd`, `host_wr` in 1: host access request; same rules as the rat side.
- `host_x`, `host_y` in ADDR_W: host cell coordinates.
- `host_din` in 1: host write data.
- `host_reload_done` in 1: one-cycle pulse, reload finished.
- `host_gnt` out 1: host access performed this cycle.
- `host_dout` out 1: host read data.
- `host_rvalid` out 1: host read data valid.
- `host_reload_req` out 1: level, asks the host to rewrite the map.
- `reload_err` out 1: sticky, set when a reload times out.
- `mem_x`, `mem_y` out ADDR_W: memory cell coordinates.
- `mem_rd`, `mem_wr` out 1: memory read and write strobes.
- `mem_din` out 1: memory write data.
- `mem_dout` in 1: memory read data, valid one cycle after `mem_rd`.

## Operation
- States:
  - NORMAL: both sides arbitrate.
  - RELOAD: host only.
- Arbitration in NORMAL:
  - If only one side requests, that side is granted.
  - If both request, the side not granted last time is granted.
  - `last_gnt` flop, reset value HOST, so the rat wins the first conflict.
  - `last_gnt` updates only on cycles with a grant.
- At most one memory access per cycle. `mem_*` is a combinational mux of the granted side. With no grant, all `mem_*` strobes are 0 and `mem_x`/`mem_y`/`mem_din` are don't-care.
- Read return:
  - The owner of a granted read is registered.
  - On the next cycle, `mem_dout` is forwarded to that side's `*_dout` and its `*_rvalid` pulses for one cycle.
  - Writes produce no `rvalid`.
- NORMAL to RELOAD on `rat_rst_map`:
  - `host_reload_req` is set.
  - `rat_busy` is set.
  - The watchdog counter is cleared.
- In RELOAD:
  - The host is always granted when it requests; the rat is never granted.
  - A rat read granted in the final NORMAL cycle still returns its `rvalid`.
- RELOAD to NORMAL on either:
  - `host_reload_done` pulse.
  - Watchdog reaching TIMEOUT-1. On timeout, `reload_err` is also set.
  - Either exit clears `host_reload_req` and `rat_busy`.
- Boundaries:
  - `rat_rst_map` while in RELOAD: ignored; watchdog not restarted.
  - `host_reload_done` while in NORMAL: ignored.
  - `host_reload_done` in the same cycle as timeout: done wins; `reload_err` unchanged.
  - `rat_rst_map` in the same cycle as a rat request: the rat access is still granted under NORMAL rules; the transition takes effect next cycle.
  - `reload_err` is cleared only by `rst`.
- Reset, asynchronous: state NORMAL, `last_gnt` HOST, watchdog 0, all `gnt`/`rvalid`/`busy`/`reload_req`/`err` outputs 0, `*_dout` 0.

## Timing
- Grant: same cycle as the request (combinational).
- Read data: at cycle N+1 for a grant at cycle N.
- `rat_busy` and `host_reload_req`: high from the cycle after the `rat_rst_map` pulse, through the `host_reload_done` cycle, low the cycle after.
- Watchdog: counts RELOAD cycles, 0 to TIMEOUT-1; width clog2(TIMEOUT).

## Structure
- Shared package `maze_pkg`:
  - State enum (NORMAL, RELOAD).
  - Owner enum (RAT, HOST).
  - `ADDR_W` and `TIMEOUT` defaults.
- Sub-module `rr_arb2`: two-requester round-robin arbiter with a `last_gnt` flop and an enable input. Elsewhere the FSM, watchdog and read-return register stay inline.

## Test plan
- Rat read of (3,5), holding 1, host idle -> `rat_gnt` at cycle N; `rat_rvalid`=1, `rat_dout`=1 at N+1; host outputs stay 0.
- Rat and host read together for 4 cycles -> grants alternate RAT, HOST, RAT, HOST; each `rvalid` lands on the correct side.
- `rat_rst_map`, host writes 256 cells, then `host_reload_done` -> `rat_busy` and `host_reload_req` high for exactly the reload window; rat request held throughout is granted the cycle after `busy` falls.
- `rat_rst_map` with no done, TIMEOUT=512 -> exit after 512 RELOAD cycles; `reload_err`=1 and stays 1 across later reloads.
- `rst` asserted mid-RELOAD with a read in flight -> all outputs 0 immediately; no `rvalid` after release; next conflict grants RAT.

Source files
------------

// File: rtl/maze_mem_arbiter_pkg.sv
// Shared types and defaults for the maze memory arbiter slice.
package maze_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 512;

  typedef enum logic {
    NORMAL = 1'b0,
    RELOAD = 1'b1
  } state_e;

  typedef enum logic {
    RAT  = 1'b0,
    HOST = 1'b1
  } owner_e;

  // Watchdog width; a degenerate TIMEOUT of 1 still needs one bit.
  function automatic int unsigned wd_width(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Rat, host and maze-RAM signal bundle for the arbiter.
interface maze_mem_arbiter_if
  import maze_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);
  // rat side
  logic              rat_rd;
  logic              rat_wr;
  logic [ADDR_W-1:0] rat_x;
  logic [ADDR_W-1:0] rat_y;
  logic              rat_din;
  logic              rat_rst_map;
  logic              rat_gnt;
  logic              rat_dout;
  logic              rat_rvalid;
  logic              rat_busy;
  // host side
  logic              host_rd;
  logic              host_wr;
  logic [ADDR_W-1:0] host_x;
  logic [ADDR_W-1:0] host_y;
  logic              host_din;
  logic              host_reload_done;
  logic              host_gnt;
  logic              host_dout;
  logic              host_rvalid;
  logic              host_reload_req;
  logic              reload_err;
  // memory side
  logic [ADDR_W-1:0] mem_x;
  logic [ADDR_W-1:0] mem_y;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_din;
  logic              mem_dout;

  modport slave (
    input  rat_rd, rat_wr, rat_x, rat_y, rat_din, rat_rst_map,
    output rat_gnt, rat_dout, rat_rvalid, rat_busy,
    input  host_rd, host_wr, host_x, host_y, host_din, host_reload_done,
    output host_gnt, host_dout, host_rvalid, host_reload_req, reload_err,
    output mem_x, mem_y, mem_rd, mem_wr, mem_din,
    input  mem_dout
  );

  modport master (
    output rat_rd, rat_wr, rat_x, rat_y, rat_din, rat_rst_map,
    input  rat_gnt, rat_dout, rat_rvalid, rat_busy,
    output host_rd, host_wr, host_x, host_y, host_din, host_reload_done,
    input  host_gnt, host_dout, host_rvalid, host_reload_req, reload_err,
    input  mem_x, mem_y, mem_rd, mem_wr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/maze_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on a conflict the side not granted last wins.
module rr_arb2
  import maze_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_rat_i,
  input  logic req_host_i,
  output logic gnt_rat_o,
  output logic gnt_host_o
);

  owner_e last_gnt_q, last_gnt_d;
  logic   gnt_rat, gnt_host;

  // Grant selection and history update; history only moves on a grant.
  always_comb begin
    gnt_rat    = 1'b0;
    gnt_host   = 1'b0;
    last_gnt_d = last_gnt_q;
    if (en_i) begin
      if (req_rat_i && (!req_host_i || last_gnt_q == HOST)) begin
        gnt_rat = 1'b1;
      end else if (req_host_i) begin
        gnt_host = 1'b1;
      end
    end
    if (gnt_rat) begin
      last_gnt_d = RAT;
    end else if (gnt_host) begin
      last_gnt_d = HOST;
    end
  end

  // Reset to HOST so the rat wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= HOST;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign gnt_rat_o  = gnt_rat;
  assign gnt_host_o = gnt_host;

endmodule

// File: rtl/maze_mem_arbiter.sv
// Maze RAM sharing between rat engine and host loader, with map-reload sequencing.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  maze_mem_arbiter_if.slave bus
);

  localparam int unsigned     WD_W    = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              rv_q, rv_d;
  owner_e            rv_owner_q, rv_owner_d;

  logic              rat_req, host_req, normal;
  logic              arb_rat, arb_host;
  logic              rat_gnt, host_gnt;
  logic              rat_rvalid, host_rvalid;
  logic [ADDR_W-1:0] mem_x, mem_y;
  logic              mem_rd, mem_wr, mem_din;

  assign rat_req  = bus.rat_rd | bus.rat_wr;
  assign host_req = bus.host_rd | bus.host_wr;
  assign normal   = (state_q == NORMAL);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (normal),
    .req_rat_i  (rat_req),
    .req_host_i (host_req),
    .gnt_rat_o  (arb_rat),
    .gnt_host_o (arb_host)
  );

  // During a reload the arbiter is bypassed: host always wins, rat is locked out.
  assign rat_gnt  = arb_rat;
  assign host_gnt = normal ? arb_host : host_req;

  // Route the granted side onto the memory port; strobes idle without a grant.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    mem_x   = bus.host_x;
    mem_y   = bus.host_y;
    mem_din = bus.host_din;
    if (rat_gnt) begin
      mem_rd  = bus.rat_rd;
      mem_wr  = bus.rat_wr;
      mem_x   = bus.rat_x;
      mem_y   = bus.rat_y;
      mem_din = bus.rat_din;
    end else if (host_gnt) begin
      mem_rd  = bus.host_rd;
      mem_wr  = bus.host_wr;
    end
  end

  // Remember who owns the read issued this cycle.
  always_comb begin
    rv_d       = (rat_gnt & bus.rat_rd) | (host_gnt & bus.host_rd);
    rv_owner_d = rat_gnt ? RAT : HOST;
  end

  // Reload sequencing and watchdog; a done pulse outranks a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    unique case (state_q)
      NORMAL: begin
        if (bus.rat_rst_map) begin
          state_d = RELOAD;
          wd_d    = '0;
        end
      end
      RELOAD: begin
        if (bus.host_reload_done) begin
          state_d = NORMAL;
        end else if (wd_q == WD_LAST) begin
          state_d = NORMAL;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // State, watchdog, sticky error and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NORMAL;
      wd_q       <= '0;
      err_q      <= 1'b0;
      rv_q       <= 1'b0;
      rv_owner_q <= RAT;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      rv_q       <= rv_d;
      rv_owner_q <= rv_owner_d;
    end
  end

  assign rat_rvalid  = rv_q & (rv_owner_q == RAT);
  assign host_rvalid = rv_q & (rv_owner_q == HOST);

  assign bus.rat_gnt         = rat_gnt;
  assign bus.rat_rvalid      = rat_rvalid;
  assign bus.rat_dout        = rat_rvalid & bus.mem_dout;
  assign bus.rat_busy        = ~normal;
  assign bus.host_gnt        = host_gnt;
  assign bus.host_rvalid     = host_rvalid;
  assign bus.host_dout       = host_rvalid & bus.mem_dout;
  assign bus.host_reload_req = ~normal;
  assign bus.reload_err      = err_q;
  assign bus.mem_x           = mem_x;
  assign bus.mem_y           = mem_y;
  assign bus.mem_rd          = mem_rd;
  assign bus.mem_wr          = mem_wr;
  assign bus.mem_din         = mem_din;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a behavioural 16x16 maze RAM.
module tb_maze_mem_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  maze_mem_arbiter_if #(.ADDR_W(4)) bus();

  maze_mem_arbiter #(.ADDR_W(4), .TIMEOUT(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Maze RAM: reset pattern is all zero except cell (3,5); index is {y,x}.
  logic mem [256];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 'h53);
      bus.mem_dout <= 1'b0;
    end else begin
      if (bus.mem_wr) mem[{bus.mem_y, bus.mem_x}] <= bus.mem_din;
      if (bus.mem_rd) bus.mem_dout <= mem[{bus.mem_y, bus.mem_x}];
    end
  end

  typedef struct packed {
    logic       rrd, rwr;
    logic [3:0] rx, ry;
    logic       rdin;
    logic       hrd, hwr;
    logic [3:0] hx, hy;
    logic       hdin;
    logic [7:0] exp; // rgnt hgnt rrv rdout hrv hdout mrd mwr
    logic [3:0] ex, ey;
    logic       edin;
  } vec_t;

  function automatic vec_t mk(input int rrd, rwr, rx, ry, rdin,
                              input int hrd, hwr, hx, hy, hdin,
                              input logic [7:0] exp, input int ex, ey, edin);
    vec_t v;
    v.rrd = 1'(rrd); v.rwr = 1'(rwr); v.rx = 4'(rx); v.ry = 4'(ry); v.rdin = 1'(rdin);
    v.hrd = 1'(hrd); v.hwr = 1'(hwr); v.hx = 4'(hx); v.hy = 4'(hy); v.hdin = 1'(hdin);
    v.exp = exp; v.ex = 4'(ex); v.ey = 4'(ey); v.edin = 1'(edin);
    return v;
  endfunction

  function automatic logic [7:0] obs8();
    return {bus.rat_gnt, bus.host_gnt, bus.rat_rvalid, bus.rat_dout,
            bus.host_rvalid, bus.host_dout, bus.mem_rd, bus.mem_wr};
  endfunction

  function automatic logic [2:0] status3();
    return {bus.rat_busy, bus.host_reload_req, bus.reload_err};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rat_rd = 0; bus.rat_wr = 0; bus.rat_x = '0; bus.rat_y = '0; bus.rat_din = 0;
    bus.rat_rst_map = 0;
    bus.host_rd = 0; bus.host_wr = 0; bus.host_x = '0; bus.host_y = '0; bus.host_din = 0;
    bus.host_reload_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("reset_outputs", 16'({obs8(), status3()}), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[17];

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int busy_cnt, bad, cnt;
    logic exited;
    logic [7:0] kk;

    vecs[0]  = mk(0,0,0,0,0, 0,0,0,0,0, 8'b0000_0000, 0,0,0);
    vecs[1]  = mk(1,0,3,5,0, 0,0,0,0,0, 8'b1000_0010, 3,5,0);
    vecs[2]  = mk(0,0,0,0,0, 0,0,0,0,0, 8'b0011_0000, 0,0,0);
    vecs[3]  = mk(0,0,0,0,0, 0,1,7,2,1, 8'b0100_0001, 7,2,1);
    vecs[4]  = mk(1,0,7,2,0, 1,0,0,0,0, 8'b1000_0010, 7,2,0);
    vecs[5]  = mk(1,0,0,0,0, 1,0,0,0,0, 8'b0111_0010, 0,0,0);
    vecs[6]  = mk(1,0,0,0,0, 1,0,3,5,0, 8'b1000_1010, 0,0,0);
    vecs[7]  = mk(1,0,0,0,0, 1,0,3,5,0, 8'b0110_0010, 3,5,0);
    vecs[8]  = mk(0,0,0,0,0, 0,0,0,0,0, 8'b0000_1100, 0,0,0);
    vecs[9]  = mk(0,1,2,2,1, 1,0,2,2,0, 8'b1000_0001, 2,2,1);
    vecs[10] = mk(0,0,0,0,0, 1,0,2,2,0, 8'b0100_0010, 2,2,0);
    vecs[11] = mk(0,0,0,0,0, 0,0,0,0,0, 8'b0000_1100, 0,0,0);
    vecs[12] = mk(0,1,9,9,0, 0,1,4,4,1, 8'b1000_0001, 9,9,0);
    vecs[13] = mk(0,0,0,0,0, 0,1,4,4,1, 8'b0100_0001, 4,4,1);
    vecs[14] = mk(1,0,4,4,0, 1,0,9,9,0, 8'b1000_0010, 4,4,0);
    vecs[15] = mk(0,0,0,0,0, 1,0,9,9,0, 8'b0111_0010, 9,9,0);
    vecs[16] = mk(0,0,0,0,0, 0,0,0,0,0, 8'b0000_1000, 0,0,0);

    // Table: single accesses, alternating conflicts, read return routing.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.rat_rd = vecs[i].rrd; bus.rat_wr = vecs[i].rwr;
      bus.rat_x = vecs[i].rx; bus.rat_y = vecs[i].ry; bus.rat_din = vecs[i].rdin;
      bus.host_rd = vecs[i].hrd; bus.host_wr = vecs[i].hwr;
      bus.host_x = vecs[i].hx; bus.host_y = vecs[i].hy; bus.host_din = vecs[i].hdin;
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), 16'(obs8()), 16'(vecs[i].exp));
      if (vecs[i].exp[1] || vecs[i].exp[0])
        chk($sformatf("vec%0d_addr", i),
            16'({bus.mem_y, bus.mem_x, bus.mem_wr & bus.mem_din}),
            16'({vecs[i].ey, vecs[i].ex, vecs[i].exp[0] & vecs[i].edin}));
      tick();
    end
    idle_inputs();

    // Reload with host rewrite; rst_map coincides with a granted rat read.
    do_reset();
    bus.rat_rd = 1; bus.rat_x = 4'd3; bus.rat_y = 4'd5; bus.rat_rst_map = 1;
    @(negedge clk);
    chk("rstmap_same_cycle", 16'({bus.rat_gnt, bus.mem_rd, bus.rat_busy}), 16'b110);
    tick();
    bus.rat_rst_map = 0;
    @(negedge clk);
    chk("reload_entry", 16'({bus.rat_gnt, bus.rat_rvalid, bus.rat_dout,
                             bus.rat_busy, bus.host_reload_req}), 16'b01111);
    busy_cnt = 1;
    bad = 0;
    tick();
    for (int k = 0; k < 256; k++) begin
      kk = 8'(k);
      bus.host_wr = 1; bus.host_x = kk[3:0]; bus.host_y = kk[7:4];
      bus.host_din = (kk == 8'h53);
      bus.rat_rst_map = (k == 10);
      @(negedge clk);
      if (bus.rat_busy) busy_cnt++;
      if (!(bus.host_gnt && bus.mem_wr && !bus.rat_gnt)) bad++;
      tick();
    end
    bus.host_wr = 0; bus.rat_rst_map = 0; bus.host_reload_done = 1;
    @(negedge clk);
    if (bus.rat_busy) busy_cnt++;
    chk("done_cycle", 16'({bus.rat_gnt, bus.rat_busy, bus.host_reload_req}), 16'b011);
    tick();
    bus.host_reload_done = 0;
    @(negedge clk);
    chk("reload_exit", 16'({bus.rat_gnt, bus.mem_rd, status3()}), 16'b11000);
    chk("busy_window", 16'(busy_cnt), 16'd258);
    chk("reload_host_only", 16'(bad), 16'd0);
    tick();
    bus.rat_rd = 0;
    @(negedge clk);
    chk("post_reload_read", 16'({bus.rat_rvalid, bus.rat_dout}), 16'b11);
    tick();
    bus.host_reload_done = 1;
    @(negedge clk);
    chk("done_in_normal", 16'(status3()), 16'b000);
    tick();
    bus.host_reload_done = 0;
    @(negedge clk);
    chk("done_in_normal_after", 16'(status3()), 16'b000);
    tick();

    // Done pulse on the timeout cycle: done wins, no error.
    do_reset();
    bus.rat_rst_map = 1;
    tick();
    bus.rat_rst_map = 0;
    for (int i = 0; i < 511; i++) tick();
    bus.host_reload_done = 1;
    @(negedge clk);
    chk("last_wd_cycle_busy", 16'(bus.rat_busy), 16'd1);
    tick();
    bus.host_reload_done = 0;
    @(negedge clk);
    chk("done_beats_timeout", 16'({bus.rat_busy, bus.reload_err}), 16'b00);
    tick();

    // Watchdog expiry; a second rst_map mid-reload must not restart it.
    bus.rat_rst_map = 1;
    tick();
    bus.rat_rst_map = 0;
    cnt = 0;
    exited = 0;
    for (int i = 0; i < 600 && !exited; i++) begin
      bus.rat_rst_map = (i == 100);
      @(negedge clk);
      if (bus.rat_busy) cnt++;
      else exited = 1;
      tick();
    end
    bus.rat_rst_map = 0;
    chk("timeout_exited", 16'(exited), 16'd1);
    chk("timeout_len", 16'(cnt), 16'd512);
    chk("timeout_err", 16'(bus.reload_err), 16'd1);

    // Error stays set across a later clean reload.
    bus.rat_rst_map = 1;
    tick();
    bus.rat_rst_map = 0;
    tick();
    tick();
    bus.host_reload_done = 1;
    tick();
    bus.host_reload_done = 0;
    @(negedge clk);
    chk("err_sticky", 16'({bus.rat_busy, bus.reload_err}), 16'b01);
    tick();

    // Reset mid-reload with a host read in flight.
    do_reset();
    bus.rat_rd = 1;
    @(negedge clk);
    chk("pre_rst_rat_grant", 16'(bus.rat_gnt), 16'd1);
    tick();
    bus.rat_rd = 0; bus.rat_rst_map = 1;
    tick();
    bus.rat_rst_map = 0; bus.host_rd = 1; bus.host_x = 4'd3; bus.host_y = 4'd5;
    @(negedge clk);
    chk("reload_host_read", 16'({bus.host_gnt, bus.rat_busy}), 16'b11);
    tick();
    bus.host_rd = 0;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 16'({obs8(), status3()}), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("no_rvalid_after_rst", 16'({bus.rat_rvalid, bus.host_rvalid}), 16'b00);
    tick();
    bus.rat_rd = 1; bus.host_rd = 1;
    @(negedge clk);
    chk("post_rst_conflict", 16'({bus.rat_gnt, bus.host_gnt}), 16'b10);
    tick();
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
